mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port instruction/data memory between the fetch path (IF port) and the load/store path (LS port) of the 5-stage core.
- Runs one memory transaction at a time through an IDLE/ADDR/RESP state machine.
- LS has priority over IF, with a starvation guard for IF.
- Takes flush_i (the jump/flush signal from ctrl) to discard an in-flight fetch, and drives hold_o back to ctrl while a load/store is unfinished.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_LS_STREAK, 4, max consecutive LS grants while if_req_i is pending before IF is forced to win (range 1..15).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_gnt_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_gnt_o  out  1  one-cycle pulse: IF request captured.
- if_rvalid_o  out  1  one-cycle pulse: if_rdata_o valid.
- if_rdata_o  out  DATA_W  fetched instruction.
- ls_req_i  in  1  load/store request; held stable until ls_gnt_o.
- ls_we_i  in  1  1 = store.
- ls_be_i  in  4  byte enables.
- ls_addr_i  in  ADDR_W  data address.
- ls_wdata_i  in  DATA_W  store data.
- ls_gnt_o  out  1  one-cycle pulse: LS request captured.
- ls_rvalid_o  out  1  one-cycle pulse: load data / store ack.
- ls_rdata_o  out  DATA_W  load data.
- flush_i  in  1  from ctrl jump_en; cancels the current/pending fetch.
- hold_o  out  1  to ctrl; high while an LS access is requested or in flight.
- mem_req_o  out  1  memory request, held until mem_gnt_i.
- mem_we_o  out  1  write enable.
- mem_be_o  out  4  byte enables.
- mem_addr_o  out  ADDR_W  address.
- mem_wdata_o  out  DATA_W  write data.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  memory response, exactly one per accepted request, at least 1 cycle after mem_gnt_i.
- mem_rdata_i  in  DATA_W  read data (write responses carry don't-care data).

Behaviour:
- Reset:
  - state=IDLE, owner=IF, drop=0, streak=0.
  - All *_o outputs 0, including registered mem_* fields and rdata registers.
  - Reset mid-transaction abandons it with no rvalid; the memory is reset on the same rst.
- IDLE arbitration (combinational, same cycle):
  - IF is eligible only when if_req_i=1 and flush_i=0.
  - LS wins if ls_req_i=1, unless IF is eligible and streak==MAX_LS_STREAK, in which case IF wins.
  - Winner's gnt_o=1 this cycle. Its fields are registered into mem_*, owner is recorded, next state is ADDR.
  - gnt_o outputs are 0 outside IDLE.
- Streak counter:
  - +1 on an LS grant while IF is eligible.
  - Cleared on an IF grant, or in any IDLE cycle with if_req_i=0.
  - Saturates at MAX_LS_STREAK.
- ADDR: mem_req_o=1 with the captured fields. On mem_gnt_i, drop mem_req_o next cycle and go to RESP. No retraction of mem_req_o, even on flush.
- RESP:
  - On mem_rvalid_i, register mem_rdata_i into the owner's rdata_o and pulse the owner's rvalid_o on the next cycle; state returns to IDLE.
  - If owner=IF and drop=1, suppress if_rvalid_o (if_rdata_o may still update).
  - A new grant is possible in the same cycle rvalid_o pulses (state is IDLE).
- Latency with a zero-wait memory: gnt at T, mem_req_o at T+1 with mem_gnt_i, mem_rvalid_i at T+2, rvalid_o at T+3. Throughput is one access per 3 cycles best case.
- Flush:
  - flush_i in ADDR or RESP with owner=IF sets drop=1. drop clears on return to IDLE.
  - flush_i in IDLE blocks an IF grant that cycle only.
  - LS transactions are never dropped.
- hold_o = ls_req_i | (owner==LS and state!=IDLE). It is combinational and falls in the cycle ls_rvalid_o pulses, if ls_req_i=0.
- Stores get ls_rvalid_o as an ack; ls_rdata_o is undefined for stores.
- mem_rvalid_i arriving in IDLE or ADDR is a protocol violation; ignore it and flag it via a simulation assertion.

Decomposition:
- Shared core defines header holds:
  - state encoding (IDLE=2'd0, ADDR=2'd1, RESP=2'd2);
  - owner encoding (IF=1'b0, LS=1'b1);
  - ADDR_W/DATA_W defaults.
- No sub-module. The arbitration, streak counter and FSM are small enough to stay inline; the target is ~200 lines.

Test Plan:
- IF-only read with zero-wait memory, if_addr_i=0x100, mem_rdata_i=0x00A00093 -> if_gnt_o at T, mem_req_o at T+1, if_rvalid_o=1 with if_rdata_o=0x00A00093 at T+3.
- if_req_i and ls_req_i both held continuously, ls_addr_i=0x2000, MAX_LS_STREAK=4 -> grant order LS,LS,LS,LS,IF,LS,...; hold_o=1 throughout.
- Store ls_we_i=1, ls_be_i=4'b0011, ls_wdata_i=0xDEADBEEF, mem_gnt_i delayed 3 cycles -> mem_req_o and mem fields stable 4 cycles, mem_be_o=4'b0011, then one ls_rvalid_o pulse.
- Fetch granted, then flush_i=1 during RESP -> mem transaction completes, if_rvalid_o stays 0, state returns to IDLE, next IF request granted normally.
- if_req_i=1 and flush_i=1 together in IDLE with ls_req_i=0 -> no if_gnt_o that cycle; grant the following cycle when flush_i=0.
- rst=1 asserted in RESP -> next cycle all outputs 0, state IDLE; later mem_rvalid_i produces no rvalid_o.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/LS memory arbiter: FSM and owner encodings
// plus default bus widths.
package mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned BE_W       = 4;
    localparam int unsigned STREAK_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Port bundle of the arbiter: fetch port, load/store port, ctrl handshake
// and the single memory port. slave = arbiter view, master = surrounding core.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              ls_req_i;
    logic              ls_we_i;
    logic [BE_W-1:0]   ls_be_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [DATA_W-1:0] ls_wdata_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [DATA_W-1:0] ls_rdata_o;

    logic              flush_i;
    logic              hold_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        input  flush_i,
        output hold_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        output flush_i,
        input  hold_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One transaction at a time; LS has priority, bounded by an IF starvation guard.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W        = DEF_ADDR_W,
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned MAX_LS_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                drop_q, drop_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    cmd_t                cmd_q, cmd_d;
    logic                mem_req_q, mem_req_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;

    logic if_elig, if_win, ls_win;

    // IDLE arbitration: LS first unless IF has been passed over MAX_LS_STREAK times
    always_comb begin
        if_elig = bus.if_req_i & ~bus.flush_i;
        ls_win  = (state_q == ST_IDLE) & ~rst & bus.ls_req_i
                & ~(if_elig & (streak_q == STREAK_MAX));
        if_win  = (state_q == ST_IDLE) & ~rst & if_elig & ~ls_win;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        drop_d      = drop_q;
        streak_d    = streak_q;
        cmd_d       = cmd_q;
        mem_req_d   = mem_req_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rvalid_d = 1'b0;
        ls_rdata_d  = ls_rdata_q;

        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (!bus.if_req_i) streak_d = '0;
                if (ls_win) begin
                    owner_d   = OWN_LS;
                    state_d   = ST_ADDR;
                    mem_req_d = 1'b1;
                    cmd_d     = '{we: bus.ls_we_i, be: bus.ls_be_i,
                                  addr: bus.ls_addr_i, wdata: bus.ls_wdata_i};
                    if (if_elig && streak_q != STREAK_MAX) streak_d = streak_q + STREAK_W'(1);
                end else if (if_win) begin
                    owner_d   = OWN_IF;
                    state_d   = ST_ADDR;
                    mem_req_d = 1'b1;
                    cmd_d     = '{we: 1'b0, be: '1, addr: bus.if_addr_i, wdata: '0};
                    streak_d  = '0;
                end
            end
            ST_ADDR: begin
                if (bus.flush_i && owner_q == OWN_IF) drop_d = 1'b1;
                if (bus.mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.flush_i && owner_q == OWN_IF) drop_d = 1'b1;
                if (bus.mem_rvalid_i) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_LS) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = bus.mem_rdata_i;
                    end else begin
                        // a flush landing together with the response also kills it
                        if_rvalid_d = ~(drop_q | bus.flush_i);
                        if_rdata_d  = bus.mem_rdata_i;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            drop_q      <= 1'b0;
            streak_q    <= '0;
            cmd_q       <= '0;
            mem_req_q   <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            drop_q      <= drop_d;
            streak_q    <= streak_d;
            cmd_q       <= cmd_d;
            mem_req_q   <= mem_req_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign bus.if_gnt_o    = if_win;
    assign bus.ls_gnt_o    = ls_win;
    assign bus.hold_o      = bus.ls_req_i | (owner_q == OWN_LS && state_q != ST_IDLE);
    assign bus.if_rvalid_o = if_rvalid_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.ls_rvalid_o = ls_rvalid_q;
    assign bus.ls_rdata_o  = ls_rdata_q;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = cmd_q.we;
    assign bus.mem_be_o    = cmd_q.be;
    assign bus.mem_addr_o  = cmd_q.addr;
    assign bus.mem_wdata_o = cmd_q.wdata;

    // A response is only legal while a transaction is waiting for it
    a_rvalid_in_resp: assert property (@(posedge clk) disable iff (rst)
        bus.mem_rvalid_i |-> state_q == ST_RESP)
        else $error("mem_rvalid_i outside RESP state");

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

    localparam int MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_LS_STREAK(MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model: transaction in flight, who owns it, memory handshake progress
    bit          m_busy, m_own_ls, m_drop, m_mreq, m_acc, m_after_rst;
    bit          m_if_rv, m_ls_rv, m_ls_load;
    int          m_streak;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_if_rd, m_ls_rd;
    bit          e_if_gnt, e_ls_gnt;

    // memory responder configuration
    bit          cfg_rand;
    int          cfg_gw, cfg_rw, gnt_wait, rv_wait;
    logic [31:0] cfg_rdata;
    bit          stale_rv;

    // observations from the most recent step
    logic        o_if_gnt, o_ls_gnt, o_hold, o_mem_req, o_if_rv, o_ls_rv;
    logic [3:0]  o_mem_be;
    logic [31:0] o_if_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_own_ls = 0; m_drop = 0; m_mreq = 0; m_acc = 0;
        m_if_rv = 0; m_ls_rv = 0; m_ls_load = 0; m_streak = 0; m_after_rst = 1;
        m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0; m_if_rd = '0; m_ls_rd = '0;
    endtask

    // one clock: memory responds, outputs checked against the model, model advances
    task automatic step();
        bit elig;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = stale_rv;
        if (!rst && m_mreq) begin
            if (gnt_wait == 0) bus.mem_gnt_i = 1'b1; else gnt_wait--;
        end
        if (!rst && m_acc) begin
            if (rv_wait == 0) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = cfg_rand ? $urandom : cfg_rdata;
            end else rv_wait--;
        end
        #1;
        elig = bus.if_req_i && !bus.flush_i;
        e_if_gnt = 0; e_ls_gnt = 0;
        if (!m_busy && !rst) begin
            if (bus.ls_req_i && !(elig && m_streak == MAX)) e_ls_gnt = 1;
            else if (elig) e_if_gnt = 1;
        end
        o_if_gnt = bus.if_gnt_o; o_ls_gnt = bus.ls_gnt_o; o_hold = bus.hold_o;
        o_mem_req = bus.mem_req_o; o_if_rv = bus.if_rvalid_o; o_ls_rv = bus.ls_rvalid_o;
        o_mem_be = bus.mem_be_o; o_if_rd = bus.if_rdata_o;

        chk("if_gnt", 64'(bus.if_gnt_o), 64'(e_if_gnt));
        chk("ls_gnt", 64'(bus.ls_gnt_o), 64'(e_ls_gnt));
        chk("hold", 64'(bus.hold_o), 64'(bus.ls_req_i | (m_busy & m_own_ls)));
        chk("mem_req", 64'(bus.mem_req_o), 64'(m_mreq));
        chk("if_rvalid", 64'(bus.if_rvalid_o), 64'(m_if_rv));
        chk("ls_rvalid", 64'(bus.ls_rvalid_o), 64'(m_ls_rv));
        if (m_if_rv || m_after_rst) chk("if_rdata", 64'(bus.if_rdata_o), 64'(m_if_rd));
        if (m_ls_load || m_after_rst) chk("ls_rdata", 64'(bus.ls_rdata_o), 64'(m_ls_rd));
        if (m_mreq || m_after_rst) begin
            chk("mem_we", 64'(bus.mem_we_o), 64'(m_we));
            chk("mem_be", 64'(bus.mem_be_o), 64'(m_be));
            chk("mem_addr", 64'(bus.mem_addr_o), 64'(m_addr));
            chk("mem_wdata", 64'(bus.mem_wdata_o), 64'(m_wdata));
        end

        if (rst) model_reset();
        else begin
            m_if_rv = 0; m_ls_rv = 0; m_ls_load = 0; m_after_rst = 0;
            if (!m_busy) begin
                m_drop = 0;
                if (!bus.if_req_i) m_streak = 0;
                if (e_ls_gnt || e_if_gnt) begin
                    m_busy = 1; m_mreq = 1; m_acc = 0; m_own_ls = e_ls_gnt;
                    gnt_wait = cfg_rand ? int'($urandom_range(0, 3)) : cfg_gw;
                end
                if (e_ls_gnt) begin
                    if (elig) m_streak = (m_streak + 1 > MAX) ? MAX : m_streak + 1;
                    m_we = bus.ls_we_i; m_be = bus.ls_be_i;
                    m_addr = bus.ls_addr_i; m_wdata = bus.ls_wdata_i;
                end else if (e_if_gnt) begin
                    m_streak = 0;
                    m_we = 1'b0; m_be = 4'hF; m_addr = bus.if_addr_i; m_wdata = '0;
                end
            end else begin
                if (bus.flush_i && !m_own_ls) m_drop = 1;
                if (m_mreq) begin
                    if (bus.mem_gnt_i) begin
                        m_mreq = 0; m_acc = 1;
                        rv_wait = cfg_rand ? int'($urandom_range(0, 2)) : cfg_rw;
                    end
                end else if (m_acc && bus.mem_rvalid_i) begin
                    m_busy = 0; m_acc = 0;
                    if (m_own_ls) begin
                        m_ls_rv = 1; m_ls_load = !m_we; m_ls_rd = bus.mem_rdata_i;
                    end else begin
                        m_if_rv = !m_drop; m_if_rd = bus.mem_rdata_i;
                    end
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        bus.if_req_i = 0; bus.ls_req_i = 0; bus.flush_i = 0;
        for (int k = 0; k < 40 && m_busy; k++) step();
        chk("drain_timeout", 64'(m_busy), 64'(0));
        step();
    endtask

    task automatic drive_random();
        if (e_if_gnt || !bus.if_req_i) begin
            bus.if_req_i  = ($urandom_range(0, 2) != 0);
            bus.if_addr_i = $urandom & 32'h0000_FFFC;
        end
        bus.flush_i = ($urandom_range(0, 7) == 0);
        if (bus.flush_i) bus.if_addr_i = $urandom & 32'h0000_FFFC;
        if (e_ls_gnt || !bus.ls_req_i) begin
            bus.ls_req_i   = ($urandom_range(0, 2) == 0);
            bus.ls_we_i    = 1'($urandom_range(0, 1));
            bus.ls_be_i    = 4'($urandom_range(1, 15));
            bus.ls_addr_i  = $urandom & 32'h0000_FFFC;
            bus.ls_wdata_i = $urandom;
        end
    endtask

    initial begin
        int t_gnt, t_req, t_rv, n, nreq, nrv, hold_bad, be_bad;
        logic [31:0] rd;
        int gseq [10];

        bus.if_req_i = 0; bus.if_addr_i = '0; bus.ls_req_i = 0; bus.ls_we_i = 0;
        bus.ls_be_i = '0; bus.ls_addr_i = '0; bus.ls_wdata_i = '0; bus.flush_i = 0;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
        cfg_rand = 0; cfg_gw = 0; cfg_rw = 0; cfg_rdata = '0; stale_rv = 0;
        gnt_wait = 0; rv_wait = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        step();

        // zero-wait fetch latency
        cfg_rdata = 32'h00A0_0093;
        bus.if_req_i = 1; bus.if_addr_i = 32'h100;
        t_gnt = -100; t_req = -1; t_rv = -1; rd = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (o_if_gnt) begin t_gnt = cyc; bus.if_req_i = 0; end
            if (o_mem_req && t_req < 0) t_req = cyc;
            if (o_if_rv) begin t_rv = cyc; rd = o_if_rd; end
        end
        chk("t1_req_latency", 64'(t_req - t_gnt), 64'(1));
        chk("t1_rvalid_latency", 64'(t_rv - t_gnt), 64'(3));
        chk("t1_rdata", 64'(rd), 64'(32'h00A0_0093));

        // starvation guard with both ports saturated
        bus.if_req_i = 1; bus.if_addr_i = 32'h104;
        bus.ls_req_i = 1; bus.ls_we_i = 0; bus.ls_be_i = 4'hF; bus.ls_addr_i = 32'h2000;
        n = 0; hold_bad = 0;
        for (int i = 0; i < 10; i++) gseq[i] = 2;
        for (int k = 0; k < 120 && n < 10; k++) begin
            step();
            if (o_ls_gnt) begin gseq[n] = 1; n++; end
            else if (o_if_gnt) begin gseq[n] = 0; n++; end
            if (o_hold !== 1'b1) hold_bad++;
        end
        for (int i = 0; i < 10; i++)
            chk($sformatf("t2_grant%0d", i), 64'(gseq[i]), 64'((i % 5 == 4) ? 0 : 1));
        chk("t2_hold", 64'(hold_bad), 64'(0));
        drain();

        // store with a slow memory grant
        cfg_gw = 3;
        bus.ls_req_i = 1; bus.ls_we_i = 1; bus.ls_be_i = 4'b0011;
        bus.ls_addr_i = 32'h3000; bus.ls_wdata_i = 32'hDEAD_BEEF;
        nreq = 0; nrv = 0; be_bad = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (o_ls_gnt) bus.ls_req_i = 0;
            if (o_mem_req) begin nreq++; if (o_mem_be !== 4'b0011) be_bad++; end
            if (o_ls_rv) nrv++;
        end
        chk("t3_req_cycles", 64'(nreq), 64'(4));
        chk("t3_be", 64'(be_bad), 64'(0));
        chk("t3_ack_pulses", 64'(nrv), 64'(1));
        cfg_gw = 0;

        // flush during RESP kills the fetch response
        cfg_rw = 2; nrv = 0; n = 0;
        bus.if_req_i = 1; bus.if_addr_i = 32'h200;
        for (int k = 0; k < 10; k++) begin
            bus.flush_i = (m_acc && n == 0);
            if (bus.flush_i) n = 1;
            step();
            if (o_if_gnt) bus.if_req_i = 0;
            if (o_if_rv) nrv++;
        end
        chk("t4_flushed_rvalid", 64'(nrv), 64'(0));
        bus.flush_i = 0; cfg_rw = 0; cfg_rdata = 32'h0000_0013;
        bus.if_req_i = 1; bus.if_addr_i = 32'h204; nrv = 0; rd = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (o_if_gnt) bus.if_req_i = 0;
            if (o_if_rv) begin nrv++; rd = o_if_rd; end
        end
        chk("t4_refetch_rvalid", 64'(nrv), 64'(1));
        chk("t4_refetch_rdata", 64'(rd), 64'(32'h0000_0013));

        // flush in IDLE blocks the fetch grant for that cycle only
        bus.if_req_i = 1; bus.if_addr_i = 32'h300; bus.flush_i = 1;
        step();
        chk("t5_blocked", 64'(o_if_gnt), 64'(0));
        bus.flush_i = 0;
        step();
        chk("t5_granted", 64'(o_if_gnt), 64'(1));
        drain();

        // reset in the middle of a load response
        cfg_rw = 3;
        bus.ls_req_i = 1; bus.ls_we_i = 0; bus.ls_be_i = 4'hF; bus.ls_addr_i = 32'h4000;
        for (int k = 0; k < 20 && !m_acc; k++) begin
            step();
            if (o_ls_gnt) bus.ls_req_i = 0;
        end
        step();
        rst = 1;
        step();
        stale_rv = 1;
        step();
        chk("t6_mem_req", 64'(o_mem_req), 64'(0));
        chk("t6_hold", 64'(o_hold), 64'(0));
        stale_rv = 0; rst = 0; cfg_rw = 0; nrv = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (o_ls_rv || o_if_rv) nrv++;
        end
        chk("t6_no_rvalid", 64'(nrv), 64'(0));

        // randomized traffic
        cfg_rand = 1;
        for (int k = 0; k < 3000; k++) begin
            drive_random();
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
